// File: rtl/sat_pkg.sv
// Shared SAT-engine definitions: default widths, scanner states and literal/clause
// field extractors used by the clause store and the clause evaluators.
package sat_pkg;

  localparam int SAT_NUM_CLAUSES         = 64;
  localparam int SAT_VAR_ID_BITS         = 8;
  localparam int SAT_NUM_VARS_PER_CLAUSE = 3;
  localparam int SAT_K                   = 16;

  localparam int SAT_LIT_W     = SAT_VAR_ID_BITS + 1;
  localparam int SAT_CL_W      = SAT_LIT_W * SAT_NUM_VARS_PER_CLAUSE;
  localparam int SAT_ROW_W     = SAT_CL_W * SAT_K;
  localparam int SAT_NUM_ROWS  = SAT_NUM_CLAUSES / SAT_K;
  localparam int SAT_ADDR_W    = $clog2(SAT_NUM_CLAUSES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Pointer width that never collapses to zero for single-row memories.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SAT_ROW_PTR_W = ptr_w(SAT_NUM_ROWS);

  function automatic logic [SAT_LIT_W-1:0] clause_lit(input logic [SAT_CL_W-1:0] cl,
                                                      input int idx);
    return cl[idx*SAT_LIT_W +: SAT_LIT_W];
  endfunction

  function automatic logic lit_neg(input logic [SAT_LIT_W-1:0] lit);
    return lit[SAT_LIT_W-1];
  endfunction

  function automatic logic [SAT_VAR_ID_BITS-1:0] lit_var(input logic [SAT_LIT_W-1:0] lit);
    return lit[SAT_VAR_ID_BITS-1:0];
  endfunction

endpackage

// File: rtl/clause_row_ram.sv
// Row-organised clause store: K-lane clause-granular write, registered full-row read.
module clause_row_ram #(
  parameter int K         = 16,
  parameter int CL_W      = 27,
  parameter int NUM_ROWS  = 4,
  parameter int ROW_PTR_W = 2,
  parameter     INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [K-1:0]              we,
  input  logic [ROW_PTR_W-1:0]      waddr,
  input  logic [CL_W-1:0]           wdata,
  input  logic                      re,
  input  logic [ROW_PTR_W-1:0]      raddr,
  output logic [K-1:0][CL_W-1:0]    rdata
);

  logic [K-1:0][CL_W-1:0] mem [NUM_ROWS];

  // Storage itself is never reset so clauses survive rst.
  always_ff @(posedge clk) begin
    for (int j = 0; j < K; j++)
      if (we[j]) mem[waddr][j] <= wdata;
  end

  // Read register only advances on re, so a stalled beat holds its data.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/clause_memory.sv
// Clause memory with a row scanner streaming K clauses per beat under valid/ready.
module clause_memory
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter     INIT_FILE             = "",
  localparam int K         = NUM_CLAUSES_PER_CYCLE,
  localparam int LIT_W     = VAR_ID_BITS + 1,
  localparam int CL_W      = LIT_W * NUM_VARS_PER_CLAUSE,
  localparam int ROW_W     = CL_W * K,
  localparam int NUM_ROWS  = NUM_CLAUSES / K,
  localparam int ADDR_W    = $clog2(NUM_CLAUSES),
  localparam int ROW_PTR_W = ptr_w(NUM_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [CL_W-1:0]      wr_clause,
  output logic                 wr_err,
  input  logic [ADDR_W:0]      cfg_num_clauses,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_W-1:0]     out_slice,
  output logic [K-1:0]         out_mask,
  output logic [ROW_PTR_W-1:0] out_row,
  output logic                 out_last
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(NUM_CLAUSES);

  state_t state, state_nx;

  logic [ADDR_W:0]        n_q, n_in, n_sel;
  logic [ROW_PTR_W-1:0]   last_q, last_in, last_sel, rd_row, wr_row;
  logic                   start_go, accept, rd_en, wr_fire, wr_inrange;
  logic [K-1:0]           mask_nx, we;
  logic                   last_nx;
  logic [K-1:0][CL_W-1:0] row_q;

  // Next row to fetch: row 0 on start, otherwise the row after the accepted one.
  always_comb begin
    n_in     = (cfg_num_clauses > CAP) ? CAP : cfg_num_clauses;
    last_in  = (n_in == '0) ? '0 : ROW_PTR_W'((int'(n_in) - 1) / K);
    start_go = (state == IDLE) && start;
    accept   = out_valid && out_ready;
    rd_en    = (start_go && (n_in != '0)) || ((state == SCAN) && accept && !out_last);
    rd_row   = start_go ? '0 : out_row + 1'b1;
    n_sel    = start_go ? n_in : n_q;
    last_sel = start_go ? last_in : last_q;
    last_nx  = (rd_row == last_sel);
    for (int j = 0; j < K; j++)
      mask_nx[j] = (int'(rd_row) * K + j) < int'(n_sel);
  end

  always_comb begin
    wr_fire    = wr_valid && wr_ready;
    wr_inrange = {1'b0, wr_addr} < CAP;
    wr_row     = ROW_PTR_W'(int'(wr_addr) / K);
    we         = '0;
    if (wr_fire && wr_inrange) we = K'(1) << (int'(wr_addr) % K);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ready = !start;
        if (start) state_nx = (n_in == '0) ? DONE : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (accept && out_last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
      n_q       <= '0;
      last_q    <= '0;
      wr_err    <= 1'b0;
    end else begin
      if (start_go) begin
        n_q    <= n_in;
        last_q <= last_in;
      end
      if (rd_en) begin
        out_valid <= 1'b1;
        out_row   <= rd_row;
        out_mask  <= mask_nx;
        out_last  <= last_nx;
      end else if (accept && out_last) begin
        out_valid <= 1'b0;
      end
      if (wr_fire && !wr_inrange) wr_err <= 1'b1;
    end
  end

  clause_row_ram #(
    .K(K), .CL_W(CL_W), .NUM_ROWS(NUM_ROWS), .ROW_PTR_W(ROW_PTR_W), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_row),
    .wdata (wr_clause),
    .re    (rd_en),
    .raddr (rd_row),
    .rdata (row_q)
  );

  assign out_slice = row_q;

endmodule

// File: tb/tb_clause_memory.sv
// Directed bench for clause_memory: reset, scans of several lengths, stalls, write rules, abort.
module tb_clause_memory;
  localparam int NC = 64, K = 16, CLW = 27, ROWW = CLW * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, wr_valid = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [5:0]      wr_addr = '0;
  logic [CLW-1:0]  wr_clause = '0;
  logic [6:0]      cfg = '0;
  logic            wr_ready, wr_err, busy, done, out_valid, out_last;
  logic [ROWW-1:0] out_slice;
  logic [K-1:0]    out_mask;
  logic [1:0]      out_row;

  logic            s_rst = 1'b1, s_wr_valid = 1'b0, s_start = 1'b0;
  logic [5:0]      s_wr_addr = '0;
  logic [CLW-1:0]  s_wr_clause = '0;
  logic [6:0]      s_cfg = '0;
  logic            s_wr_ready, s_wr_err, s_busy, s_done, s_out_valid, s_out_last;
  logic [ROWW-1:0] s_out_slice;
  logic [K-1:0]    s_out_mask;
  logic [1:0]      s_out_row;

  clause_memory dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_clause(wr_clause), .wr_err(wr_err), .cfg_num_clauses(cfg), .start(start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_slice(out_slice), .out_mask(out_mask), .out_row(out_row), .out_last(out_last)
  );

  clause_memory #(.NUM_CLAUSES(48)) dut48 (
    .clk(clk), .rst(s_rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr),
    .wr_clause(s_wr_clause), .wr_err(s_wr_err), .cfg_num_clauses(s_cfg), .start(s_start),
    .busy(s_busy), .done(s_done), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_slice(s_out_slice), .out_mask(s_out_mask), .out_row(s_out_row), .out_last(s_out_last)
  );

  int total = 0, bad = 0;
  logic [CLW-1:0] mdl [NC];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CLW-1:0] cl(input int c);
    logic [7:0] a, b, d;
    a = 8'(c); b = 8'(c + 1); d = 8'(c + 2);
    return {1'b0, a, 1'b0, b, 1'b0, d};
  endfunction

  function automatic logic [ROWW-1:0] row_exp(input int r);
    logic [ROWW-1:0] v;
    for (int j = 0; j < K; j++) v[j*CLW +: CLW] = mdl[r*K + j];
    return v;
  endfunction

  task automatic wr(input int a, input logic [CLW-1:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 6'(a); wr_clause = d;
    @(negedge clk);
    wr_valid = 1'b0;
    mdl[a] = d;
  endtask

  // Start a scan of n clauses and score every beat; bp randomises out_ready.
  task automatic run_scan(input int n, input bit bp);
    int nn, rr, beats, acc_last;
    bit stall, got_done, rdy;
    logic [K-1:0] m;
    logic [ROWW+K+2:0] held;
    nn = (n > NC) ? NC : n;
    rr = (nn + K - 1) / K;
    beats = 0; acc_last = -1; stall = 1'b0; got_done = 1'b0; held = '0;
    @(negedge clk);
    cfg = 7'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_vld", out_valid, nn > 0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        chk("done_time", cyc, acc_last + 1);
        chk("beats", beats, rr);
        chk("vld_at_done", out_valid, 0);
        chk("busy_at_done", busy, 1);
        break;
      end
      if (stall && out_valid) chk("stable", {out_slice, out_mask, out_row, out_last}, held);
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (!bp) chk("nobubble", out_valid, 1);
      if (out_valid && rdy) begin
        for (int j = 0; j < K; j++) m[j] = (beats * K + j) < nn;
        chk("row", out_row, beats);
        chk("slice", out_slice, row_exp(beats));
        chk("mask", out_mask, m);
        chk("last", out_last, beats == rr - 1);
        beats++;
        acc_last = cyc;
      end
      stall = out_valid && !rdy;
      held = {out_slice, out_mask, out_row, out_last};
      @(negedge clk);
    end
    if (!got_done) chk("scan_timeout", 0, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_1cyc", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_slice", out_slice, 0);
    chk("rst_mask", out_mask, 0);
    chk("rst_row", out_row, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_wr_ready", wr_ready, 1);

    for (int c = 0; c < NC; c++) wr(c, cl(c));

    run_scan(64, 1'b0);
    run_scan(20, 1'b0);
    run_scan(0, 1'b0);
    run_scan(100, 1'b0);
    run_scan(64, 1'b1);
    run_scan(37, 1'b1);
    wr(21, 27'h5A5A5A5);
    run_scan(64, 1'b1);

    // Write colliding with start, held into SCAN, then abort with rst.
    @(negedge clk);
    cfg = 7'd64; start = 1'b1; out_ready = 1'b0;
    wr_valid = 1'b1; wr_addr = 6'd5; wr_clause = 27'h7FFFFFF;
    #1 chk("wr_rdy_start", wr_ready, 0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_rdy_scan", wr_ready, 0);
      chk("busy_scan", busy, 1);
      chk("stall_row", out_row, 0);
      @(negedge clk);
    end
    wr_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_row", out_row, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_valid", out_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done2", done, 0);
    chk("abort_slice", out_slice, 0);
    run_scan(64, 1'b0);
    chk("wr_err_main", wr_err, 0);

    // Out-of-range write on a 48-clause instance, where such addresses exist.
    s_rst = 1'b0;
    @(negedge clk);
    chk("s_rst_err", s_wr_err, 0);
    s_wr_valid = 1'b1; s_wr_addr = 6'd2; s_wr_clause = 27'h1234567;
    @(negedge clk);
    s_wr_addr = 6'd50; s_wr_clause = 27'h7654321;
    @(negedge clk);
    s_wr_valid = 1'b0;
    chk("s_wr_err", s_wr_err, 1);
    repeat (3) @(negedge clk);
    chk("s_wr_err_sticky", s_wr_err, 1);
    s_cfg = 7'd48; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_vld", s_out_valid, 1);
    chk("s_lane2", s_out_slice[2*CLW +: CLW], 27'h1234567);
    for (int i = 0; i < 20; i++) begin
      if (s_done) break;
      @(negedge clk);
    end
    chk("s_done", s_done, 1);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    @(negedge clk);
    chk("s_err_clr", s_wr_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
